uart_tx: RTL

- Serial transmit stage of the UART. It sits directly upstream of the UART receive block and drives the single-wire line that the receiver samples.
- Accepts one 8-bit word over a valid/ready handshake and serialises it as one frame: start bit, 8 data bits LSB first, optional parity bit, stop bit(s).
- Default timing is one bit per clk, which is the rate the receive stage samples at.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_tx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and line levels,
// common to the transmit and receive stages.
package uart_pkg;

    localparam int   DATA_W    = 8;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period. Held at zero whenever enable is low.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (!enable || r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    assign bit_tick = enable && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one byte over valid/ready and sends
// start, 8 data bits LSB first, optional parity and 1-2 stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
    localparam int SW       = $clog2(STOP_LEN + 1);

    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be >= 1");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_e       r_state;
    logic [DATA_W-1:0] r_shift;
    logic [2:0]        r_bit_cnt;
    logic              r_parity;
    logic [SW-1:0]     r_stop_cnt;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;
    logic              w_tick;
    logic              w_baud_en;

    assign w_baud_en = (r_state != IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .enable  (w_baud_en),
        .bit_tick(w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_parity   <= 1'b0;
            r_stop_cnt <= '0;
            r_tx       <= LINE_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx   <= LINE_IDLE;
                    r_busy <= 1'b0;
                    if (tx_valid) begin
                        r_shift   <= tx_data;
                        r_parity  <= (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
                        r_bit_cnt <= '0;
                        r_tx      <= START_LVL;
                        r_busy    <= 1'b1;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= {1'b0, r_shift[DATA_W-1:1]};
                        if (r_bit_cnt == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= PARITY;
                            end else begin
                                r_tx       <= LINE_IDLE;
                                r_stop_cnt <= SW'(STOP_LEN - 1);
                                r_done     <= (STOP_LEN == 1);
                                r_state    <= STOP;
                            end
                        end else begin
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_tx       <= LINE_IDLE;
                        r_stop_cnt <= SW'(STOP_LEN - 1);
                        r_done     <= (STOP_LEN == 1);
                        r_state    <= STOP;
                    end
                end
                STOP: begin
                    // r_stop_cnt counts remaining stop cycles; tx_done is raised
                    // one edge early so it lines up with the final stop cycle.
                    if (r_stop_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_stop_cnt <= r_stop_cnt - SW'(1);
                        r_done     <= (r_stop_cnt == SW'(1));
                    end
                end
                default: begin
                    r_tx    <= LINE_IDLE;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready = (r_state == IDLE);
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign tx_done  = r_done;

endmodule
